// File: rtl/ras_stack_ckpt.sv
// ras_stack_ckpt -- return address stack with branch checkpoint/restore.
//
// Circular return-address stack. A call pushes its return address, a return
// pops. Optionally (compile with RAS_CHECKPOINT_EN defined) every fetched
// branch snapshots the stack pointers {index, count} into a small FIFO. A
// misprediction flush rolls the pointers back to the oldest snapshot. Only
// pointers are restored, never array contents.
//
// Parameters:
//   ADDR_W     return-address width
//   DEPTH      stack entries (power of two, >= 2)
//   CKPT_DEPTH checkpoint FIFO entries (power of two, >= 2)
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   push / pop     call / return fetched
//   new_addr       return address to push
//   branch_fetched snapshot {index, count} (pre-update values)
//   branch_retired release the oldest snapshot
//   flush          restore the oldest snapshot and empty the FIFO
//   addr           top-of-stack entry (undefined while valid==0)
//   valid          count != 0
//   count          live entry count, saturates at DEPTH
//   ckpt_full      checkpoint FIFO holds CKPT_DEPTH entries
//   ckpt_overflow  sticky; a snapshot was dropped. Cleared by flush.
//
// Macro RAS_CHECKPOINT_EN: enables the checkpoint FIFO. When it is undefined,
// branch_fetched, branch_retired and flush are ignored, and ckpt_full and
// ckpt_overflow are tied low.

module ras_stack_ckpt #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 8,
    parameter int CKPT_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          new_addr,
    input  logic                       branch_fetched,
    input  logic                       branch_retired,
    input  logic                       flush,
    output logic [ADDR_W-1:0]          addr,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ckpt_full,
    output logic                       ckpt_overflow
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;

    // Checkpoint hooks consumed by the pointer logic.
    logic              blocked;      // flush owns this cycle
    logic              restore_vld;  // flush with a snapshot available
    logic [IDX_W-1:0]  ck_idx;
    logic [CNT_W-1:0]  ck_cnt;

`ifdef RAS_CHECKPOINT_EN
    localparam int CK_W = $clog2(CKPT_DEPTH);
    localparam logic [CK_W:0] CK_MAX = (CK_W+1)'(CKPT_DEPTH);

    logic [IDX_W+CNT_W-1:0] ck_mem_q [CKPT_DEPTH];
    logic [CK_W-1:0]        ck_rd_q, ck_wr_q;
    logic [CK_W:0]          ck_num_q;
    logic                   ovf_q;
    logic                   ck_full, ck_empty, ck_enq, ck_deq;

    assign ck_full  = (ck_num_q == CK_MAX);
    assign ck_empty = (ck_num_q == '0);
    // A retire in the same cycle frees a slot, so a full FIFO still accepts.
    assign ck_enq   = branch_fetched & (~ck_full | branch_retired);
    assign ck_deq   = branch_retired & ~ck_empty;

    assign blocked          = flush;
    assign restore_vld      = flush & ~ck_empty;
    assign {ck_idx, ck_cnt} = ck_mem_q[ck_rd_q];
    assign ckpt_full        = ck_full;
    assign ckpt_overflow    = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ck_rd_q  <= '0;
            ck_wr_q  <= '0;
            ck_num_q <= '0;
            ovf_q    <= 1'b0;
        end else if (flush) begin
            ck_rd_q  <= '0;
            ck_wr_q  <= '0;
            ck_num_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (ck_enq) ck_wr_q <= ck_wr_q + 1'b1;
            if (ck_deq) ck_rd_q <= ck_rd_q + 1'b1;
            case ({ck_enq, ck_deq})
                2'b10:   ck_num_q <= ck_num_q + 1'b1;
                2'b01:   ck_num_q <= ck_num_q - 1'b1;
                default: ck_num_q <= ck_num_q;
            endcase
            if (branch_fetched && !ck_enq) ovf_q <= 1'b1;
        end
    end

    // Snapshot storage is not reset; occupancy is tracked by ck_num_q.
    always_ff @(posedge clk) begin
        if (rst && !flush && ck_enq) ck_mem_q[ck_wr_q] <= {idx_q, cnt_q};
    end
`else
    localparam int UNUSED_CKPT_DEPTH = CKPT_DEPTH;
    logic unused_ckpt_in;
    assign unused_ckpt_in = &{1'b0, branch_fetched, branch_retired, flush,
                              UNUSED_CKPT_DEPTH[0]};

    assign blocked       = 1'b0;
    assign restore_vld   = 1'b0;
    assign ck_idx        = '0;
    assign ck_cnt        = '0;
    assign ckpt_full     = 1'b0;
    assign ckpt_overflow = 1'b0;
`endif

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = idx_q;
        if (restore_vld) begin
            idx_d = ck_idx;
            cnt_d = ck_cnt;
        end else if (!blocked) begin
            if (push && pop) begin
                // Return immediately followed by a call: replace the top entry.
                wr_en = 1'b1;
                if (cnt_q == '0) cnt_d = CNT_W'(1);
            end else if (push) begin
                wr_en  = 1'b1;
                wr_idx = idx_q + 1'b1;
                idx_d  = idx_q + 1'b1;
                // At full, the push overwrites the oldest entry.
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end else if (pop && cnt_q != '0) begin
                idx_d = idx_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

    // Array contents are not reset. Reset abandons an in-flight push.
    always_ff @(posedge clk) begin
        if (rst && wr_en) mem_q[wr_idx] <= new_addr;
    end

    assign addr  = mem_q[idx_q];
    assign valid = (cnt_q != '0);
    assign count = cnt_q;

endmodule

// File: tb/tb_ras_stack_ckpt.sv
// Directed bench for ras_stack_ckpt. Expectations are queued before each
// clock edge and checked #1 after it. Checkpoint expectations follow
// RAS_CHECKPOINT_EN.

module tb_ras_stack_ckpt;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8;
    localparam int CKPT_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              push = 1'b0, pop = 1'b0;
    logic [ADDR_W-1:0] new_addr = '0;
    logic              branch_fetched = 1'b0, branch_retired = 1'b0, flush = 1'b0;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic [$clog2(DEPTH):0] count;
    logic              ckpt_full, ckpt_overflow;

    ras_stack_ckpt #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CKPT_DEPTH(CKPT_DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .new_addr(new_addr),
        .branch_fetched(branch_fetched), .branch_retired(branch_retired),
        .flush(flush), .addr(addr), .valid(valid), .count(count),
        .ckpt_full(ckpt_full), .ckpt_overflow(ckpt_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;   // 0 addr, 1 count, 2 valid, 3 ckpt_full, 4 ckpt_overflow
        logic [63:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic ex(input string tag, input int sel, input logic [63:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        sbq.push_back(e);
    endtask

    // Shorthand for the common count/addr/valid triple.
    task automatic ex_st(input string tag, input int cnt, input logic [63:0] a);
        ex({tag, ".count"}, 1, 64'(cnt));
        ex({tag, ".valid"}, 2, (cnt != 0) ? 64'd1 : 64'd0);
        if (cnt != 0) ex({tag, ".addr"}, 0, a);
    endtask

    task automatic drain();
        exp_t e;
        logic [63:0] obs;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            case (e.sel)
                0:       obs = 64'(addr);
                1:       obs = 64'(count);
                2:       obs = 64'(valid);
                3:       obs = 64'(ckpt_full);
                default: obs = 64'(ckpt_overflow);
            endcase
            n_cmp++;
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // One clock with the given inputs, then check what was queued.
    task automatic cyc(input logic p, input logic q, input logic [ADDR_W-1:0] a,
                       input logic bf, input logic br, input logic fl);
        push = p; pop = q; new_addr = a;
        branch_fetched = bf; branch_retired = br; flush = fl;
        @(posedge clk);
        #1;
        push = 0; pop = 0; branch_fetched = 0; branch_retired = 0; flush = 0;
        drain();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(0, 0, '0, 0, 0, 0);
        rst = 1'b1;
    endtask

    initial begin
        // Reset state
        ex_st("rst", 0, 0);
        ex("rst.full", 3, 0);
        ex("rst.ovf", 4, 0);
        rst = 1'b0;
        cyc(0, 0, '0, 0, 0, 0);
        cyc(0, 0, '0, 0, 0, 0);
        rst = 1'b1;

        // Basic push/pop
        ex_st("push1", 1, 'h100); cyc(1, 0, 'h100, 0, 0, 0);
        ex_st("push2", 2, 'h200); cyc(1, 0, 'h200, 0, 0, 0);
        ex_st("push3", 3, 'h300); cyc(1, 0, 'h300, 0, 0, 0);
        ex_st("pop1", 2, 'h200);  cyc(0, 1, '0, 0, 0, 0);

        // Simultaneous push+pop at count 2, then drain and repeat at count 0
        ex_st("pp2", 2, 'hABC);   cyc(1, 1, 'hABC, 0, 0, 0);
        ex_st("pop2", 1, 'h100);  cyc(0, 1, '0, 0, 0, 0);
        ex_st("pop3", 0, 0);      cyc(0, 1, '0, 0, 0, 0);
        ex_st("pop_empty", 0, 0); cyc(0, 1, '0, 0, 0, 0);
        ex_st("pp0", 1, 'hABC);   cyc(1, 1, 'hABC, 0, 0, 0);

        // Wrap-around: 9 pushes into 8 entries, then drain
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            ex_st($sformatf("wpush%0d", i), (i > DEPTH) ? DEPTH : i, 64'(i * 'h10));
            cyc(1, 0, ADDR_W'(i * 'h10), 0, 0, 0);
        end
        for (int k = 1; k <= 8; k++) begin
            ex_st($sformatf("wpop%0d", k), 8 - k, 64'('h90 - k * 'h10));
            cyc(0, 1, '0, 0, 0, 0);
        end

        // Checkpoint / flush
        do_reset();
        ex_st("ck.push", 1, 'h100); cyc(1, 0, 'h100, 0, 0, 0);
        ex("ck.bf.full", 3, 0);     cyc(0, 0, '0, 1, 0, 0);
        ex_st("ck.push2", 2, 'h200); cyc(1, 0, 'h200, 0, 0, 0);
        ex_st("ck.push3", 3, 'h300); cyc(1, 0, 'h300, 0, 0, 0);
`ifdef RAS_CHECKPOINT_EN
        ex_st("ck.flush", 1, 'h100);
`else
        ex_st("ck.flush", 3, 'h300);
`endif
        ex("ck.flush.full", 3, 0);
        cyc(0, 0, '0, 0, 0, 1);

        // Fill the checkpoint FIFO; a fetch+retire pair on full drops nothing.
        for (int i = 1; i <= 4; i++) begin
`ifdef RAS_CHECKPOINT_EN
            ex($sformatf("ck.fill%0d", i), 3, (i == 4) ? 64'd1 : 64'd0);
`else
            ex($sformatf("ck.fill%0d", i), 3, 0);
`endif
            ex($sformatf("ck.fill%0d.ovf", i), 4, 0);
            cyc(0, 0, '0, 1, 0, 0);
        end
`ifdef RAS_CHECKPOINT_EN
        ex("ck.bfbr.full", 3, 1);
`else
        ex("ck.bfbr.full", 3, 0);
`endif
        ex("ck.bfbr.ovf", 4, 0);
        cyc(0, 0, '0, 1, 1, 0);
`ifdef RAS_CHECKPOINT_EN
        ex("ck.drop.full", 3, 1);
        ex("ck.drop.ovf", 4, 1);
`else
        ex("ck.drop.full", 3, 0);
        ex("ck.drop.ovf", 4, 0);
`endif
        cyc(0, 0, '0, 1, 0, 0);

`ifdef RAS_CHECKPOINT_EN
        ex_st("ck.push5", 2, 'h500); cyc(1, 0, 'h500, 0, 0, 0);
        ex_st("ck.flush2", 1, 'h100);
        ex("ck.flush2.ovf", 4, 0);
        ex("ck.flush2.full", 3, 0);
        cyc(0, 0, '0, 0, 0, 1);
        // Empty FIFO: flush leaves pointers alone and still masks the push.
        ex_st("ck.flushpush", 1, 'h100);
        cyc(1, 0, 'h400, 0, 0, 1);
`else
        ex_st("ck.push5", 4, 'h500); cyc(1, 0, 'h500, 0, 0, 0);
        ex_st("ck.flush2", 4, 'h500);
        ex("ck.flush2.ovf", 4, 0);
        cyc(0, 0, '0, 0, 0, 1);
        ex_st("ck.flushpush", 5, 'h400);
        cyc(1, 0, 'h400, 0, 0, 1);
`endif

        // Reset mid-sequence at count 5, with a push in flight.
        do_reset();
        for (int i = 1; i <= 5; i++) cyc(1, 0, ADDR_W'('h1000 + i), 1, 0, 0);
        ex_st("mid.pre", 5, 'h1005);
        cyc(0, 0, '0, 0, 0, 0);
        ex_st("mid.rst", 0, 0);
        ex("mid.rst.full", 3, 0);
        ex("mid.rst.ovf", 4, 0);
        rst = 1'b0;
        cyc(1, 0, 'hDEAD, 1, 0, 0);
        rst = 1'b1;
        ex_st("mid.after", 1, 'h777);
        cyc(1, 0, 'h777, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ras_stack_ckpt.md
RAS_STACK_CKPT -- requirements
Module: ras_stack_ckpt

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, return-address width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, stack entries; power of two, at least 2.
REQ-003 SHALL have parameter CKPT_DEPTH, default 4, in-flight branch checkpoints; power of two, at least 2.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-006 SHALL have port push  in  1  call fetched: push new_addr.
REQ-007 SHALL have port pop  in  1  return fetched: pop the top entry.
REQ-008 SHALL have port new_addr  in  ADDR_W  return address to push.
REQ-009 SHALL have port branch_fetched  in  1  capture a checkpoint of the stack pointer.
REQ-010 SHALL have port branch_retired  in  1  release the oldest checkpoint.
REQ-011 SHALL have port flush  in  1  misprediction: restore the oldest checkpoint.
REQ-012 SHALL have port addr  out  ADDR_W  current top-of-stack address.
REQ-013 SHALL have port valid  out  1  stack holds at least one entry (count != 0).
REQ-014 SHALL have port count  out  $clog2(DEPTH)+1  live entry count.
REQ-015 SHALL have port ckpt_full  out  1  checkpoint queue holds CKPT_DEPTH entries.
REQ-016 SHALL have port ckpt_overflow  out  1  sticky: a checkpoint was dropped.

Function
REQ-017 SHALL store entries in a circular array indexed by a log2(DEPTH)-bit read index; addr SHALL be the array entry at the read index, read combinationally from registered state.
REQ-018 SHALL, on push only: write new_addr at index+1 (mod DEPTH), increment the index, and set count to min(count+1, DEPTH); the new addr SHALL appear the cycle after the edge.
REQ-019 SHALL, on push at count==DEPTH, silently overwrite the oldest entry (wrap-around); count SHALL stay DEPTH.
REQ-020 SHALL, on pop only with count>0: decrement the index (mod DEPTH) and decrement count.
REQ-021 SHALL ignore pop only at count==0: index unchanged, count 0, valid 0.
REQ-022 SHALL, on push and pop in the same cycle: overwrite the entry at the current index with new_addr, leaving index and count unchanged; if count==0, count SHALL become 1.
REQ-023 SHALL, on branch_fetched, enqueue {index, count} as held before this cycle's push/pop into a CKPT_DEPTH FIFO.
REQ-024 SHALL, on branch_fetched while ckpt_full, drop the checkpoint and set ckpt_overflow.
REQ-025 SHALL dequeue the oldest checkpoint on branch_retired; branch_retired on an empty queue SHALL be ignored.
REQ-026 SHALL accept simultaneous branch_fetched and branch_retired on a full queue: both take effect and nothing is dropped.
REQ-027 SHALL, on flush with a non-empty queue, load index and count from the oldest checkpoint, empty the queue and clear ckpt_overflow.
REQ-028 SHALL, on flush with an empty queue, leave index and count unchanged and clear ckpt_overflow.
REQ-029 SHALL give flush priority over push, pop, branch_fetched and branch_retired in the same cycle; those inputs SHALL be ignored that cycle.
REQ-030 SHALL restore only pointers on flush, not array contents; entries overwritten after the checkpoint SHALL stay overwritten.

Reset
REQ-031 SHALL, while rst==0 at a clock edge, set index 0, count 0, valid 0, checkpoint queue empty, ckpt_full 0 and ckpt_overflow 0.
REQ-032 SHALL NOT reset array contents; addr SHALL be undefined while valid==0.
REQ-033 SHALL abandon any in-progress push, pop or checkpoint when reset is applied mid-operation, with the reset state taking effect at that same edge.

Configuration
REQ-034 SHALL, with RAS_CHECKPOINT_EN defined, implement REQ-023 to REQ-030.
REQ-035 SHALL, without RAS_CHECKPOINT_EN: have no checkpoint FIFO; ignore branch_fetched, branch_retired and flush; tie ckpt_full and ckpt_overflow to 0; leave push/pop behaviour identical.

Verification
REQ-036 SHALL cover: reset, then push 0x100, 0x200, 0x300 -> count 3, addr 0x300; pop -> addr 0x200, count 2.
REQ-037 SHALL cover, with DEPTH=8: 9 pushes of 0x10..0x90 -> count 8, addr 0x90; 8 pops -> count 0, valid 0, and the last addr before empty is 0x20 (0x10 overwritten).
REQ-038 SHALL cover: push and pop together with new_addr 0xABC at count 2 -> count 2, addr 0xABC; the same at count 0 -> count 1, addr 0xABC.
REQ-039 SHALL cover: push 0x100, branch_fetched, push 0x200, push 0x300, flush -> count 1, addr 0x100, ckpt queue empty.
REQ-040 SHALL cover, with CKPT_DEPTH=4: 5 branch_fetched -> ckpt_full 1, ckpt_overflow 1; flush -> ckpt_overflow 0; and flush asserted together with push 0x400 -> push ignored.
REQ-041 SHALL cover: rst low for one edge mid-sequence at count 5 -> count 0, valid 0, ckpt_full 0 on the next cycle.
